// File: rtl/alu_op_issue.sv
// alu_op_issue
//   Decodes RV32 ALU instructions (R-type and I-type subsets) at push time and
//   buffers the decoded operation in a small FIFO ahead of the ALU stage.
//   Undecodable instructions travel through the queue flagged as illegal and
//   are counted.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  push handshake for instr + operands
//   instr                RV32 instruction word
//   rs1_data, rs2_data   register-file operand values
//   out_valid/out_ready  pop handshake for the queue head
//   alu_ctrl, alu_a,     decoded head: ALU op select, operands,
//   alu_b, rd, illegal   destination index, illegal flag
//   illegal_cnt          saturating count of illegal instructions accepted
module alu_op_issue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  rd,
    output logic        illegal,
    output logic [15:0] illegal_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } entry_t;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   illegal_cnt_q, illegal_cnt_d;
    entry_t        mem_q [DEPTH];
    entry_t        dec;
    entry_t        head;
    logic          push;
    logic          pop;

    // rs1 register index is consumed by the register file upstream, not here.
    logic unused_rs1_idx;
    assign unused_rs1_idx = ^instr[19:15];

    // ---------------------------------------------------------------- decode
    always_comb begin
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       legal;
        opcode   = instr[6:0];
        funct3   = instr[14:12];
        funct7   = instr[31:25];
        legal    = 1'b0;
        dec      = '0;
        dec.rd   = instr[11:7];
        if (opcode == OP_R) begin
            legal = ((funct7 == 7'b0000000) &&
                     (funct3 == 3'b000 || funct3 == 3'b100 ||
                      funct3 == 3'b110 || funct3 == 3'b111)) ||
                    ((funct7 == 7'b0100000) && (funct3 == 3'b000));
            if (legal) begin
                dec.ctrl = {instr[30], funct3};
                dec.a    = rs1_data;
                dec.b    = rs2_data;
            end
        end else if (opcode == OP_I) begin
            legal = (funct3 == 3'b000 || funct3 == 3'b100 ||
                     funct3 == 3'b110 || funct3 == 3'b111);
            if (legal) begin
                dec.ctrl = {1'b0, funct3};
                dec.a    = rs1_data;
                dec.b    = {{20{instr[31]}}, instr[31:20]};
            end
        end
        dec.ill = ~legal;
    end

    // ---------------------------------------------------------------- queue control
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        illegal_cnt_d = illegal_cnt_q;
        // DEPTH is a power of two, so plain pointer overflow wraps modulo DEPTH.
        if (push) wr_ptr_d = PW'(wr_ptr_q + 1'b1);
        if (pop)  rd_ptr_d = PW'(rd_ptr_q + 1'b1);
        case ({push, pop})
            2'b10:   count_d = CW'(count_q + 1'b1);
            2'b01:   count_d = CW'(count_q - 1'b1);
            default: count_d = count_q;
        endcase
        if (push && dec.ill && (illegal_cnt_q != 16'hFFFF))
            illegal_cnt_d = illegal_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            illegal_cnt_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the queue is empty,
    // which also covers the all-zero requirement while reset is held.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec;
    end

    // ---------------------------------------------------------------- outputs
    assign head        = out_valid ? mem_q[rd_ptr_q] : '0;
    assign alu_ctrl    = head.ctrl;
    assign alu_a       = head.a;
    assign alu_b       = head.b;
    assign rd          = head.rd;
    assign illegal     = head.ill;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed testbench for alu_op_issue (DEPTH = 2).
module tb_alu_op_issue;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  rd;
    logic        illegal;
    logic [15:0] illegal_cnt;

    int checks = 0;
    int errors = 0;

    alu_op_issue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_ctrl    (alu_ctrl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .rd          (rd),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {out_valid, alu_ctrl, alu_a, alu_b, rd, illegal}
    logic [74:0] obs;
    assign obs = {out_valid, alu_ctrl, alu_a, alu_b, rd, illegal};

    function automatic logic [74:0] exp_e(input logic v, input logic [3:0] c,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] r, input logic il);
        return {v, c, a, b, r, il};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rdi);
        return {f7, 5'd2, 5'd1, f3, rdi, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                          input logic [4:0] rdi);
        return {imm, 5'd1, f3, rdi, 7'b0010011};
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        instr     = ins;
        rs1_data  = a;
        rs2_data  = b;
        out_ready = ordy;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; instr = enc_r(7'd0, 3'b000, 5'd3);
        rs1_data = 32'hDEAD; rs2_data = 32'hBEEF; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        checks++;
        if (obs !== '0 || illegal_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: obs=%h cnt=%h want 0", obs, illegal_cnt);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        drive(1'b1, enc_r(7'd0, 3'b000, 5'd3), 32'd5, 32'd7, 1'b0);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_no_comb_path: out_valid=%b want 0", out_valid);
        end
        edge_sample();
        checks++;
        if (obs !== exp_e(1'b1, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b0)) begin
            errors++;
            $display("FAIL add_head: got %h want %h", obs,
                     exp_e(1'b1, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b0));
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        edge_sample();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_sub_xori();
        logic [74:0] e_sub;
        logic [74:0] e_xori;
        e_sub  = exp_e(1'b1, 4'b1000, 32'd10, 32'd3, 5'd5, 1'b0);
        e_xori = exp_e(1'b1, 4'b0100, 32'd9, 32'hFFFFFFFF, 5'd4, 1'b0);
        drive(1'b1, enc_r(7'b0100000, 3'b000, 5'd5), 32'd10, 32'd3, 1'b0);
        @(posedge clk);
        drive(1'b1, enc_i(12'hFFF, 3'b100, 5'd4), 32'd9, 32'd0, 1'b0);
        edge_sample();
        checks++;
        if (obs !== e_sub) begin
            errors++;
            $display("FAIL sub_head: got %h want %h", obs, e_sub);
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        edge_sample();
        checks++;
        if (obs !== e_xori) begin
            errors++;
            $display("FAIL xori_head: got %h want %h", obs, e_xori);
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        edge_sample();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sub_xori_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_full();
        logic [74:0] e0;
        logic [74:0] e1;
        e0 = exp_e(1'b1, 4'b0110, 32'h1111, 32'h2222, 5'd6, 1'b0);
        e1 = exp_e(1'b1, 4'b0111, 32'd33, 32'd44, 5'd7, 1'b0);
        drive(1'b1, enc_r(7'd0, 3'b110, 5'd6), 32'h1111, 32'h2222, 1'b0);
        edge_sample();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_one_entry: in_ready=%b want 1", in_ready);
        end
        drive(1'b1, enc_r(7'd0, 3'b111, 5'd7), 32'd33, 32'd44, 1'b0);
        edge_sample();
        checks++;
        if (in_ready !== 1'b0 || obs !== e0) begin
            errors++;
            $display("FAIL full_reached: in_ready=%b head=%h want 0 %h", in_ready, obs, e0);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, enc_i(12'h123, 3'b000, 5'd8), 32'd77, 32'd0, 1'b0);
            edge_sample();
            checks++;
            if (in_ready !== 1'b0 || obs !== e0) begin
                errors++;
                $display("FAIL full_hold[%0d]: in_ready=%b head=%h want 0 %h", k, in_ready, obs, e0);
            end
        end
        // Pop while full with in_valid still high: the push must stay blocked.
        drive(1'b1, enc_i(12'h123, 3'b000, 5'd8), 32'd77, 32'd0, 1'b1);
        edge_sample();
        checks++;
        if (in_ready !== 1'b1 || obs !== e1) begin
            errors++;
            $display("FAIL full_pop: in_ready=%b head=%h want 1 %h", in_ready, obs, e1);
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        edge_sample();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_extra_rejected: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [74:0] e;
        drive(1'b1, enc_i(12'd0, 3'b000, 5'd0), 32'd0, 32'd0, 1'b1);
        @(posedge clk);
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, enc_i(12'(i), 3'b000, 5'(i)), 32'(i * 100), 32'd0, 1'b1);
            edge_sample();
            e = exp_e(1'b1, 4'b0000, 32'(i * 100), 32'(i), 5'(i), 1'b0);
            checks++;
            if (obs !== e || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d]: head=%h in_ready=%b want %h 1", i, obs, in_ready, e);
            end
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        edge_sample();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] vec [4];
        logic [4:0]  rdv [4];
        logic [74:0] e;
        vec[0] = enc_r(7'b0100000, 3'b100, 5'd9);              rdv[0] = 5'd9;
        vec[1] = {12'h000, 5'd1, 3'b010, 5'd10, 7'b0000011};    rdv[1] = 5'd10;
        vec[2] = enc_i(12'h001, 3'b001, 5'd11);                 rdv[2] = 5'd11;
        vec[3] = enc_r(7'b0000001, 3'b000, 5'd12);              rdv[3] = 5'd12;
        // First two are queued together before being drained.
        drive(1'b1, vec[0], 32'd5, 32'd6, 1'b0);
        edge_sample();
        checks++;
        if (illegal_cnt !== 16'd1) begin
            errors++;
            $display("FAIL illegal_cnt1: got %0d want 1", illegal_cnt);
        end
        drive(1'b1, vec[1], 32'd5, 32'd6, 1'b0);
        edge_sample();
        checks++;
        if (illegal_cnt !== 16'd2) begin
            errors++;
            $display("FAIL illegal_cnt2: got %0d want 2", illegal_cnt);
        end
        for (int k = 0; k < 2; k++) begin
            e = exp_e(1'b1, 4'b0000, 32'd0, 32'd0, rdv[k], 1'b1);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL illegal_head[%0d]: got %h want %h", k, obs, e);
            end
            drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
            edge_sample();
        end
        for (int k = 2; k < 4; k++) begin
            drive(1'b1, vec[k], 32'd5, 32'd6, 1'b0);
            edge_sample();
            e = exp_e(1'b1, 4'b0000, 32'd0, 32'd0, rdv[k], 1'b1);
            checks++;
            if (obs !== e || illegal_cnt !== 16'(k + 1)) begin
                errors++;
                $display("FAIL illegal_head[%0d]: got %h cnt=%0d want %h cnt=%0d",
                         k, obs, illegal_cnt, e, k + 1);
            end
            drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
            edge_sample();
        end
        checks++;
        if (out_valid !== 1'b0 || illegal_cnt !== 16'd4) begin
            errors++;
            $display("FAIL illegal_drain: out_valid=%b cnt=%0d want 0 4", out_valid, illegal_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [74:0] e;
        e = exp_e(1'b1, 4'b0100, 32'd3, 32'd5, 5'd13, 1'b0);
        drive(1'b1, enc_r(7'd0, 3'b000, 5'd1), 32'd1, 32'd1, 1'b0);
        @(posedge clk);
        drive(1'b1, enc_r(7'd0, 3'b000, 5'd2), 32'd2, 32'd2, 1'b0);
        edge_sample();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_setup: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_cnt !== 16'd0 || obs !== '0) begin
            errors++;
            $display("FAIL rmid_async: out_valid=%b in_ready=%b cnt=%0d obs=%h want 0 1 0 0",
                     out_valid, in_ready, illegal_cnt, obs);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        instr     = enc_r(7'd0, 3'b100, 5'd13);
        rs1_data  = 32'd3;
        rs2_data  = 32'd5;
        out_ready = 1'b0;
        edge_sample();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL rmid_first_push: got %h want %h", obs, e);
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        edge_sample();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_alone: out_valid=%b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_xori();
        test_full();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
